// File: rtl/lector_destinos.sv
// rtl/lector_destinos.sv - round-robin drain of destination FIFOs D0/D1 onto one registered valid/ready stream
module lector_destinos #(
  parameter int BW       = 6,
  parameter int DEST_BIT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             D0_empty,
  input  logic             D0_error_output,
  input  logic [BW-1:0]    D0_data_out,
  input  logic             D1_empty,
  input  logic             D1_error_output,
  input  logic [BW-1:0]    D1_data_out,
  input  logic             out_ready,
  output logic             D0_rd,
  output logic             D1_rd,
  output logic [BW-1:0]    data_out,
  output logic             dest_out,
  output logic             valid_out,
  output logic             dest_err,
  output logic [CNT_W-1:0] cnt_D0,
  output logic [CNT_W-1:0] cnt_D1,
  output logic             idle
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_state_next;
  // Most recent grant; it also names the FIFO whose word is in flight.
  logic            r_last;
  logic            w_el0;
  logic            w_el1;
  logic            w_any;
  logic            w_win;
  logic            w_grant;
  logic [BW-1:0]   w_cap_data;

  assign w_el0 = ~D0_empty & ~D0_error_output;
  assign w_el1 = ~D1_empty & ~D1_error_output;
  assign w_any = w_el0 | w_el1;
  // On a tie the FIFO not granted last time wins; otherwise the only eligible one.
  assign w_win = (w_el0 & w_el1) ? ~r_last : w_el1;

  assign w_cap_data = r_last ? D1_data_out : D0_data_out;

  // Pop strobes are held low during reset so a reset never advances a FIFO.
  assign D0_rd = w_grant & ~w_win & ~reset;
  assign D1_rd = w_grant &  w_win & ~reset;

  assign valid_out = (r_state == S_HOLD);
  assign idle      = (r_state == S_IDLE) & ~w_any;

  // Next-state and grant decision; eligibility only matters where a pop can issue.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant      = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          if (w_any) begin
            w_grant      = 1'b1;
            w_state_next = S_WAIT;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_last <= w_win;
      end
    end
  end

  // Capture the popped word one cycle after the pop, tag-check it and count it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      dest_out <= 1'b0;
      dest_err <= 1'b0;
      cnt_D0   <= '0;
      cnt_D1   <= '0;
    end else if (r_state == S_WAIT) begin
      data_out <= w_cap_data;
      dest_out <= r_last;
      if (w_cap_data[DEST_BIT] != r_last) begin
        dest_err <= 1'b1;
      end
      if (r_last) begin
        cnt_D1 <= cnt_D1 + CNT_ONE;
      end else begin
        cnt_D0 <= cnt_D0 + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_lector_destinos.sv
// tb/tb_lector_destinos.sv - scoreboard bench for lector_destinos with FIFO models for D0/D1
module tb_lector_destinos;

  logic       clk = 1'b0;
  logic       reset;
  logic       d0_empty = 1'b1;
  logic       d1_empty = 1'b1;
  logic       D0_error_output;
  logic       D1_error_output;
  logic [5:0] d0_dout = 6'h00;
  logic [5:0] d1_dout = 6'h00;
  logic       out_ready;
  logic       D0_rd;
  logic       D1_rd;
  logic [5:0] data_out;
  logic       dest_out;
  logic       valid_out;
  logic       dest_err;
  logic [7:0] cnt_D0;
  logic [7:0] cnt_D1;
  logic       idle;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [7:0] exp_q[$];
  logic       grant_q[$];
  int         rd_cyc[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int d0_pulses = 0;
  int d1_pulses = 0;

  logic       prev_hold = 1'b0;
  logic [5:0] prev_data = 6'h00;
  logic       prev_dest = 1'b0;

  lector_destinos #(.BW(6), .DEST_BIT(4), .CNT_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .D0_empty        (d0_empty),
    .D0_error_output (D0_error_output),
    .D0_data_out     (d0_dout),
    .D1_empty        (d1_empty),
    .D1_error_output (D1_error_output),
    .D1_data_out     (d1_dout),
    .out_ready       (out_ready),
    .D0_rd           (D0_rd),
    .D1_rd           (D1_rd),
    .data_out        (data_out),
    .dest_out        (dest_out),
    .valid_out       (valid_out),
    .dest_err        (dest_err),
    .cnt_D0          (cnt_D0),
    .cnt_D1          (cnt_D1),
    .idle            (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic f, input logic [5:0] w);
    if (f) q1.push_back(w);
    else   q0.push_back(w);
  endtask

  task automatic expect_word(input logic d, input logic [5:0] w, input logic e);
    exp_q.push_back({e, d, w});
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || valid_out) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  // FIFO read side: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    cyc++;
    if (D0_rd && q0.size() > 0) d0_dout <= q0.pop_front();
    if (D1_rd && q1.size() > 0) d1_dout <= q1.pop_front();
  end

  // Empty flags settle after pops at the edge and after stimulus at edge+2.
  always @(posedge clk) begin
    #3;
    d0_empty = (q0.size() == 0);
    d1_empty = (q1.size() == 0);
  end

  // Monitor: pop strobes, hold stability, and scoreboard on each accepted word.
  always @(negedge clk) begin
    logic [7:0] e;
    if (D0_rd | D1_rd) begin
      chk("rd_onehot", 32'(D0_rd & D1_rd), 32'd0);
      if (D0_rd) begin d0_pulses++; rd_cyc.push_back(cyc); grant_q.push_back(1'b0); end
      if (D1_rd) begin d1_pulses++; grant_q.push_back(1'b1); end
    end
    if (valid_out) begin
      if (prev_hold) begin
        chk("hold_data", 32'(data_out), 32'(prev_data));
        chk("hold_dest", 32'(dest_out), 32'(prev_dest));
      end
      if (!out_ready) begin
        chk("hold_no_rd", 32'(D0_rd | D1_rd), 32'd0);
        prev_hold = 1'b1;
        prev_data = data_out;
        prev_dest = dest_out;
      end else begin
        prev_hold = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", 32'(data_out), 32'(e[5:0]));
          chk("sb_dest", 32'(dest_out), 32'(e[6]));
          chk("sb_err",  32'(dest_err), 32'(e[7]));
        end
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int p;
    logic [5:0] w;
    logic [3:0] lo;

    reset = 1'b1;
    out_ready = 1'b1;
    D0_error_output = 1'b0;
    D1_error_output = 1'b0;
    load(1'b0, 6'h01);
    load(1'b1, 6'h11);

    // Reset with both FIFOs non-empty.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_d0_rd", 32'(D0_rd), 32'd0);
    chk("rst_d1_rd", 32'(D1_rd), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_dest", 32'(dest_out), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_err", 32'(dest_err), 32'd0);
    chk("rst_cnt0", 32'(cnt_D0), 32'd0);
    chk("rst_cnt1", 32'(cnt_D1), 32'd0);
    chk("rst_idle_busy", 32'(idle), 32'd0);
    @(posedge clk); #2;
    q0.delete();
    q1.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_idle_empty", 32'(idle), 32'd1);
    chk("rst_no_pulses", 32'(d0_pulses + d1_pulses), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Single source D0, three words.
    rd_cyc.delete();
    load(1'b0, 6'b00_0001); expect_word(1'b0, 6'b00_0001, 1'b0);
    load(1'b0, 6'b00_1100); expect_word(1'b0, 6'b00_1100, 1'b0);
    load(1'b0, 6'b00_0101); expect_word(1'b0, 6'b00_0101, 1'b0);
    drain(100, "single_timeout");
    chk("single_rd_count", 32'(rd_cyc.size()), 32'd3);
    if (rd_cyc.size() == 3) begin
      chk("single_rd_gap1", 32'(rd_cyc[1] - rd_cyc[0]), 32'd2);
      chk("single_rd_gap2", 32'(rd_cyc[2] - rd_cyc[1]), 32'd2);
    end
    chk("single_cnt0", 32'(cnt_D0), 32'd3);
    chk("single_err", 32'(dest_err), 32'd0);

    // Tie arbitration from reset: D0 first.
    do_reset();
    grant_q.delete();
    load(1'b0, 6'h02); load(1'b0, 6'h03);
    load(1'b1, 6'h12); load(1'b1, 6'h13);
    expect_word(1'b0, 6'h02, 1'b0);
    expect_word(1'b1, 6'h12, 1'b0);
    expect_word(1'b0, 6'h03, 1'b0);
    expect_word(1'b1, 6'h13, 1'b0);
    drain(100, "tie_timeout");
    chk("tie_grants", 32'(grant_q.size()), 32'd4);
    if (grant_q.size() == 4) begin
      chk("tie_order", 32'({grant_q[0], grant_q[1], grant_q[2], grant_q[3]}), 32'b0101);
    end
    chk("tie_cnt0", 32'(cnt_D0), 32'd2);
    chk("tie_cnt1", 32'(cnt_D1), 32'd2);

    // Backpressure: five cycles stalled in HOLD.
    out_ready = 1'b0;
    load(1'b0, 6'h07); expect_word(1'b0, 6'h07, 1'b0);
    load(1'b0, 6'h08); expect_word(1'b0, 6'h08, 1'b0);
    n = 0;
    while (!valid_out && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk("bp_valid_timeout", 32'(n < 50), 32'd1);
    p = d0_pulses;
    repeat (5) @(posedge clk);
    #2;
    chk("bp_no_pulses", 32'(d0_pulses), 32'(p));
    chk("bp_data_held", 32'(data_out), 32'h07);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rd_on_ready", 32'(D0_rd), 32'd1);
    @(posedge clk); #2;
    chk("bp_transferred", 32'(valid_out), 32'd0);
    drain(100, "bp_timeout");

    // Wrong destination tag from D1.
    load(1'b1, 6'b01_0001); expect_word(1'b1, 6'b01_0001, 1'b0);
    load(1'b1, 6'b00_1111); expect_word(1'b1, 6'b00_1111, 1'b1);
    drain(100, "tag_timeout");
    chk("tag_err_set", 32'(dest_err), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    chk("tag_err_sticky", 32'(dest_err), 32'd1);

    // D0 blocked by its error flag; only D1 is read.
    do_reset();
    D0_error_output = 1'b1;
    load(1'b0, 6'h01); load(1'b0, 6'h02);
    load(1'b1, 6'h13); expect_word(1'b1, 6'h13, 1'b0);
    load(1'b1, 6'h14); expect_word(1'b1, 6'h14, 1'b0);
    drain(100, "errflag_timeout");
    chk("errflag_d0_left", 32'(q0.size()), 32'd2);
    chk("errflag_cnt0", 32'(cnt_D0), 32'd0);
    chk("errflag_cnt1", 32'(cnt_D1), 32'd2);

    // 254 more D1 words: 256 captures in total wrap cnt_D1 to 0.
    for (int i = 0; i < 254; i++) begin
      lo = i[3:0];
      w = {2'b01, lo};
      load(1'b1, w);
      expect_word(1'b1, w, 1'b0);
    end
    drain(1500, "wrap_timeout");
    chk("wrap_cnt1", 32'(cnt_D1), 32'd0);

    // Release the error flag; the held D0 words now drain.
    expect_word(1'b0, 6'h01, 1'b0);
    expect_word(1'b0, 6'h02, 1'b0);
    D0_error_output = 1'b0;
    drain(100, "release_timeout");
    chk("release_cnt0", 32'(cnt_D0), 32'd2);

    // Reset while the popped word is in flight: it is dropped.
    load(1'b0, 6'h05);
    n = 0;
    while (!D0_rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_rd_timeout", 32'(n < 20), 32'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_valid", 32'(valid_out), 32'd0);
    chk("midrst_cnt0", 32'(cnt_D0), 32'd0);
    chk("midrst_fifo_popped", 32'(q0.size()), 32'd0);
    chk("midrst_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
